mem_arbiter: RTL and testbench

- Shares the single DPI-backed memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time and forwards it to memory. Routes the response back to the requester that issued it.
- LSU has priority. A starvation counter guarantees the IFU forward progress.
- A watchdog timer terminates transactions that never receive a response.

---
 rtl/mem_arbiter_if.sv | 60 ++++++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Groups every handshake and data signal around the memory arbiter:
//   - IFU side : fetch request (valid/ready/addr) and response (valid/rdata)
//   - LSU side : load/store request (valid/ready/addr/wen/wdata/wmask) and
//                response (valid/rdata); the response also acknowledges stores
//   - Memory   : request (valid/ready/addr/wen/wdata/wmask), response
//                (valid/rdata) and the bus_err timeout pulse
// Modports:
//   slave  - the arbiter's view (requests and memory responses in, the rest out)
//   master - the view of the environment around the arbiter (IFU, LSU and memory)
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ifu_req_valid;
   logic              ifu_req_ready;
   logic [ADDR_W-1:0] ifu_addr;
   logic              ifu_resp_valid;
   logic [DATA_W-1:0] ifu_rdata;

   logic              lsu_req_valid;
   logic              lsu_req_ready;
   logic [ADDR_W-1:0] lsu_addr;
   logic              lsu_wen;
   logic [DATA_W-1:0] lsu_wdata;
   logic [3:0]        lsu_wmask;
   logic              lsu_resp_valid;
   logic [DATA_W-1:0] lsu_rdata;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_rdata;

   logic              bus_err;

   modport slave (
      input  ifu_req_valid, ifu_addr,
      input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      input  mem_req_ready, mem_resp_valid, mem_rdata,
      output ifu_req_ready, ifu_resp_valid, ifu_rdata,
      output lsu_req_ready, lsu_resp_valid, lsu_rdata,
      output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      output bus_err
   );

   modport master (
      output ifu_req_valid, ifu_addr,
      output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
      output mem_req_ready, mem_resp_valid, mem_rdata,
      input  ifu_req_ready, ifu_resp_valid, ifu_rdata,
      input  lsu_req_ready, lsu_resp_valid, lsu_rdata,
      input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
      input  bus_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between the instruction fetch unit (IFU) and the
// load/store unit (LSU). One transaction is outstanding at a time; the
// response is routed back to whichever requester issued it. The LSU normally
// wins arbitration, but after STARVE_LIMIT consecutive LSU grants while the
// IFU waits, the IFU is served. A watchdog ends a transaction that has waited
// TIMEOUT cycles without a response, pulsing bus_err and returning zero data.
// Ports:
//   clock - system clock
//   reset - synchronous, active-high; abandons any outstanding access
//   bus   - mem_arbiter_if.slave carrying the IFU, LSU and memory signals
module mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input logic          clock,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
   localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, WAIT_IFU, WAIT_LSU} arbState_t;

   arbState_t         state, nextState;
   logic [3:0]        starveCnt, starveCntNext;
   logic [7:0]        timer, timerNext;
   logic [DATA_W-1:0] ifuRdataQ, ifuRdataNext;
   logic [DATA_W-1:0] lsuRdataQ, lsuRdataNext;
   logic              grantIfu, grantLsu;

   // State register plus the held copies of the last response data.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         starveCnt <= '0;
         timer     <= '0;
         ifuRdataQ <= '0;
         lsuRdataQ <= '0;
      end else begin
         state     <= nextState;
         starveCnt <= starveCntNext;
         timer     <= timerNext;
         ifuRdataQ <= ifuRdataNext;
         lsuRdataQ <= lsuRdataNext;
      end
   end

   // Arbitration, memory request muxing and response routing.
   // The response strobe passes straight through in the cycle memory answers,
   // and the rdata output shows mem_rdata in that same cycle while the
   // register keeps it afterwards. A response arriving in IDLE is ignored.
   // While reset is high every output is forced to its reset value so that a
   // late response in the reset cycle cannot leak out.
   always_comb begin
      nextState     = state;
      starveCntNext = starveCnt;
      timerNext     = timer;
      ifuRdataNext  = ifuRdataQ;
      lsuRdataNext  = lsuRdataQ;
      grantIfu      = 1'b0;
      grantLsu      = 1'b0;

      bus.ifu_req_ready  = 1'b0;
      bus.ifu_resp_valid = 1'b0;
      bus.ifu_rdata      = ifuRdataQ;
      bus.lsu_req_ready  = 1'b0;
      bus.lsu_resp_valid = 1'b0;
      bus.lsu_rdata      = lsuRdataQ;
      bus.mem_req_valid  = 1'b0;
      bus.mem_addr       = {ADDR_W{1'b0}};
      bus.mem_wen        = 1'b0;
      bus.mem_wdata      = {DATA_W{1'b0}};
      bus.mem_wmask      = 4'b0000;
      bus.bus_err        = 1'b0;

      case (state)
         IDLE: begin
            grantIfu = bus.ifu_req_valid &&
                       (!bus.lsu_req_valid || starveCnt == STARVE_MAX);
            grantLsu = !grantIfu && bus.lsu_req_valid;
            if (grantIfu) begin
               bus.mem_req_valid = 1'b1;
               bus.mem_addr      = bus.ifu_addr;
               bus.ifu_req_ready = bus.mem_req_ready;
               if (bus.mem_req_ready) begin
                  nextState     = WAIT_IFU;
                  timerNext     = '0;
                  starveCntNext = '0;
               end
            end else if (grantLsu) begin
               bus.mem_req_valid = 1'b1;
               bus.mem_addr      = bus.lsu_addr;
               bus.mem_wen       = bus.lsu_wen;
               bus.mem_wdata     = bus.lsu_wdata;
               bus.mem_wmask     = bus.lsu_wmask;
               bus.lsu_req_ready = bus.mem_req_ready;
               if (bus.mem_req_ready) begin
                  nextState = WAIT_LSU;
                  timerNext = '0;
                  // Count only LSU wins that actually made the IFU wait.
                  if (!bus.ifu_req_valid) begin
                     starveCntNext = '0;
                  end else if (starveCnt != STARVE_MAX) begin
                     starveCntNext = starveCnt + 4'd1;
                  end
               end
            end
         end

         WAIT_IFU: begin
            timerNext = timer + 8'd1;
            if (bus.mem_resp_valid) begin
               bus.ifu_resp_valid = 1'b1;
               bus.ifu_rdata      = bus.mem_rdata;
               ifuRdataNext       = bus.mem_rdata;
               nextState          = IDLE;
            end else if (timer == TIMEOUT_VAL) begin
               bus.bus_err        = 1'b1;
               bus.ifu_resp_valid = 1'b1;
               bus.ifu_rdata      = {DATA_W{1'b0}};
               ifuRdataNext       = {DATA_W{1'b0}};
               nextState          = IDLE;
            end
         end

         WAIT_LSU: begin
            timerNext = timer + 8'd1;
            if (bus.mem_resp_valid) begin
               bus.lsu_resp_valid = 1'b1;
               bus.lsu_rdata      = bus.mem_rdata;
               lsuRdataNext       = bus.mem_rdata;
               nextState          = IDLE;
            end else if (timer == TIMEOUT_VAL) begin
               bus.bus_err        = 1'b1;
               bus.lsu_resp_valid = 1'b1;
               bus.lsu_rdata      = {DATA_W{1'b0}};
               lsuRdataNext       = {DATA_W{1'b0}};
               nextState          = IDLE;
            end
         end

         default: nextState = IDLE;
      endcase

      if (reset) begin
         bus.ifu_req_ready  = 1'b0;
         bus.ifu_resp_valid = 1'b0;
         bus.ifu_rdata      = {DATA_W{1'b0}};
         bus.lsu_req_ready  = 1'b0;
         bus.lsu_resp_valid = 1'b0;
         bus.lsu_rdata      = {DATA_W{1'b0}};
         bus.mem_req_valid  = 1'b0;
         bus.mem_addr       = {ADDR_W{1'b0}};
         bus.mem_wen        = 1'b0;
         bus.mem_wdata      = {DATA_W{1'b0}};
         bus.mem_wmask      = 4'b0000;
         bus.bus_err        = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed, self-checking bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=255).
// Each grant pushes the response the requester should receive onto a
// scoreboard queue; the entry is popped and compared when the arbiter
// delivers a response. Inputs change on the falling edge and outputs are
// sampled 1 ns later, well away from the rising edge.
module tb_mem_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arbBus ();

   mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .STARVE_LIMIT(4),
      .TIMEOUT(255)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(arbBus.slave)
   );

   typedef struct {
      bit          isLsu;
      logic [31:0] data;
      bit          checkData;
      bit          err;
   } respEntry_t;

   respEntry_t  expQ[$];
   int          checks = 0;
   int          errors = 0;

   logic        rstLevel  = 1'b1;
   logic        ifuValid  = 1'b0;
   logic [31:0] ifuAddr   = '0;
   logic        lsuValid  = 1'b0;
   logic [31:0] lsuAddr   = '0;
   logic        lsuWen    = 1'b0;
   logic [31:0] lsuWdata  = '0;
   logic [3:0]  lsuWmask  = '0;

   // Global guard so the bench always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive all inputs at the falling edge, then settle for sampling.
   task automatic applyStimulus(input logic mrdy, input logic mrv, input logic [31:0] mrd);
      @(negedge clock);
      reset                 = rstLevel;
      arbBus.ifu_req_valid  = ifuValid;
      arbBus.ifu_addr       = ifuAddr;
      arbBus.lsu_req_valid  = lsuValid;
      arbBus.lsu_addr       = lsuAddr;
      arbBus.lsu_wen        = lsuWen;
      arbBus.lsu_wdata      = lsuWdata;
      arbBus.lsu_wmask      = lsuWmask;
      arbBus.mem_req_ready  = mrdy;
      arbBus.mem_resp_valid = mrv;
      arbBus.mem_rdata      = mrd;
      #1;
   endtask

   // Checks a grant in the current cycle and records the expected response.
   task automatic checkGrant(input bit expLsu, input logic [31:0] respData, input bit err);
      checkOutput("mem_req_valid", arbBus.mem_req_valid, 1);
      if (expLsu) begin
         checkOutput("lsu_req_ready", arbBus.lsu_req_ready, 1);
         checkOutput("ifu_req_ready", arbBus.ifu_req_ready, 0);
         checkOutput("mem_addr", arbBus.mem_addr, lsuAddr);
         checkOutput("mem_wen", arbBus.mem_wen, lsuWen);
         checkOutput("mem_wmask", arbBus.mem_wmask, lsuWmask);
         if (lsuWen) checkOutput("mem_wdata", arbBus.mem_wdata, lsuWdata);
      end else begin
         checkOutput("ifu_req_ready", arbBus.ifu_req_ready, 1);
         checkOutput("lsu_req_ready", arbBus.lsu_req_ready, 0);
         checkOutput("mem_addr", arbBus.mem_addr, ifuAddr);
         checkOutput("mem_wen", arbBus.mem_wen, 0);
         checkOutput("mem_wmask", arbBus.mem_wmask, 0);
      end
      expQ.push_back('{expLsu, respData, !(expLsu && lsuWen), err});
   endtask

   // Memory answers with the oldest expected data; the arbiter must route it.
   task automatic respStep();
      respEntry_t e;
      if (expQ.size() == 0) begin
         checkOutput("scoreboard_nonempty", 0, 1);
         return;
      end
      e = expQ.pop_front();
      applyStimulus(1'b1, 1'b1, e.data);
      checkOutput("mem_req_valid_wait", arbBus.mem_req_valid, 0);
      checkOutput("ifu_req_ready_wait", arbBus.ifu_req_ready, 0);
      checkOutput("lsu_req_ready_wait", arbBus.lsu_req_ready, 0);
      checkOutput("ifu_resp_valid", arbBus.ifu_resp_valid, !e.isLsu);
      checkOutput("lsu_resp_valid", arbBus.lsu_resp_valid, e.isLsu);
      checkOutput("bus_err", arbBus.bus_err, e.err);
      if (e.checkData) begin
         if (e.isLsu) checkOutput("lsu_rdata", arbBus.lsu_rdata, e.data);
         else         checkOutput("ifu_rdata", arbBus.ifu_rdata, e.data);
      end
   endtask

   initial begin
      bit          seq[10];
      bit          seen;
      int          waited;
      respEntry_t  e;

      arbBus.ifu_req_valid  = 1'b0;
      arbBus.ifu_addr       = '0;
      arbBus.lsu_req_valid  = 1'b0;
      arbBus.lsu_addr       = '0;
      arbBus.lsu_wen        = 1'b0;
      arbBus.lsu_wdata      = '0;
      arbBus.lsu_wmask      = '0;
      arbBus.mem_req_ready  = 1'b0;
      arbBus.mem_resp_valid = 1'b0;
      arbBus.mem_rdata      = '0;

      // Reset values.
      rstLevel = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      rstLevel = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("rst_ifu_req_ready", arbBus.ifu_req_ready, 0);
      checkOutput("rst_lsu_req_ready", arbBus.lsu_req_ready, 0);
      checkOutput("rst_mem_req_valid", arbBus.mem_req_valid, 0);
      checkOutput("rst_mem_wen", arbBus.mem_wen, 0);
      checkOutput("rst_bus_err", arbBus.bus_err, 0);
      checkOutput("rst_ifu_rdata", arbBus.ifu_rdata, 0);
      checkOutput("rst_lsu_rdata", arbBus.lsu_rdata, 0);

      // IFU-only fetch answered one cycle after acceptance.
      ifuValid = 1'b1;
      ifuAddr  = 32'h8000_0000;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b0, 32'h0000_0413, 1'b0);
      ifuValid = 1'b0;
      respStep();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("ifu_rdata_held", arbBus.ifu_rdata, 32'h0000_0413);
      checkOutput("ifu_resp_pulse", arbBus.ifu_resp_valid, 0);

      // Spurious memory response in IDLE is ignored.
      applyStimulus(1'b1, 1'b1, 32'h1234_5678);
      checkOutput("spur_ifu_resp", arbBus.ifu_resp_valid, 0);
      checkOutput("spur_lsu_resp", arbBus.lsu_resp_valid, 0);
      checkOutput("spur_ifu_rdata", arbBus.ifu_rdata, 32'h0000_0413);

      // Simultaneous requests: LSU store first, then IFU.
      ifuValid = 1'b1;
      ifuAddr  = 32'h8000_0004;
      lsuValid = 1'b1;
      lsuAddr  = 32'h8000_1000;
      lsuWen   = 1'b1;
      lsuWdata = 32'hDEAD_BEEF;
      lsuWmask = 4'hF;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b1, 32'h5555_5555, 1'b0);
      lsuValid = 1'b0;
      respStep();
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b0, 32'h0000_0013, 1'b0);
      ifuValid = 1'b0;
      respStep();

      // Memory stalls for three cycles; the request waits with a stable address.
      ifuValid = 1'b1;
      ifuAddr  = 32'h8000_0008;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkOutput("stall_ifu_req_ready", arbBus.ifu_req_ready, 0);
         checkOutput("stall_mem_req_valid", arbBus.mem_req_valid, 1);
         checkOutput("stall_mem_addr", arbBus.mem_addr, 32'h8000_0008);
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b0, 32'h0000_0093, 1'b0);
      respStep();

      // Both continuously valid: four LSU grants, then the IFU, repeatedly.
      seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      ifuValid = 1'b1;
      ifuAddr  = 32'h8000_000C;
      lsuValid = 1'b1;
      lsuAddr  = 32'h8000_2000;
      lsuWen   = 1'b0;
      lsuWmask = 4'h0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         checkGrant(seq[i], 32'h1000 + 32'(i), 1'b0);
         respStep();
      end

      // LSU load that memory never answers.
      ifuValid = 1'b0;
      lsuValid = 1'b1;
      lsuAddr  = 32'h8000_3000;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b1, 32'h0, 1'b1);
      lsuValid = 1'b0;
      seen   = 1'b0;
      waited = 0;
      for (int n = 0; n < 300; n++) begin
         applyStimulus(1'b1, 1'b0, 32'hBAD0_BAD0);
         if (arbBus.bus_err || arbBus.lsu_resp_valid) begin
            seen   = 1'b1;
            waited = n;
            break;
         end
      end
      checkOutput("timeout_seen", seen, 1);
      checkOutput("timeout_cycle", waited, 255);
      if (seen && expQ.size() != 0) begin
         e = expQ.pop_front();
         checkOutput("timeout_bus_err", arbBus.bus_err, e.err);
         checkOutput("timeout_lsu_resp", arbBus.lsu_resp_valid, 1);
         checkOutput("timeout_lsu_rdata", arbBus.lsu_rdata, e.data);
         checkOutput("timeout_ifu_resp", arbBus.ifu_resp_valid, 0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("timeout_err_once", arbBus.bus_err, 0);
      ifuValid = 1'b1;
      ifuAddr  = 32'h8000_0010;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b0, 32'h0000_0513, 1'b0);
      ifuValid = 1'b0;
      respStep();

      // Reset while waiting on the IFU, then a late memory response.
      ifuValid = 1'b1;
      ifuAddr  = 32'h8000_0014;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b0, 32'h0000_0077, 1'b0);
      ifuValid = 1'b0;
      rstLevel = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h0000_0077);
      checkOutput("rstmid_ifu_resp", arbBus.ifu_resp_valid, 0);
      checkOutput("rstmid_bus_err", arbBus.bus_err, 0);
      expQ.delete();
      rstLevel = 1'b0;
      applyStimulus(1'b1, 1'b1, 32'h0000_0078);
      checkOutput("late_ifu_resp", arbBus.ifu_resp_valid, 0);
      checkOutput("late_lsu_resp", arbBus.lsu_resp_valid, 0);
      checkOutput("late_bus_err", arbBus.bus_err, 0);
      checkOutput("late_mem_req_valid", arbBus.mem_req_valid, 0);
      checkOutput("late_ifu_rdata", arbBus.ifu_rdata, 0);
      checkOutput("late_lsu_rdata", arbBus.lsu_rdata, 0);
      ifuValid = 1'b1;
      ifuAddr  = 32'h8000_0018;
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkGrant(1'b0, 32'h0000_0613, 1'b0);
      ifuValid = 1'b0;
      respStep();

      checkOutput("scoreboard_empty", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
